render_scheduler: RTL and testbench

- Shares the single pixel-sweep datapath and framebuffer write port between up to NUM_REQ drawing clients (clear, box fill, glyph blit, cursor).
- Arbitrates round-robin, latches the winner's pixel count, and sweeps pixel index 0..limit-1 while generating x/y coordinates incrementally, with no divider.
- Honours a framebuffer back-pressure stall and pulses a per-client done strobe.
- Sits between the draw engines and the VGA framebuffer writer.

---
 rtl/render_scheduler_pkg.sv | 16 +
 rtl/render_scheduler_if.sv | 34 +++
 rtl/render_scheduler_rr_arbiter.sv | 32 +++
 rtl/render_scheduler.sv | 125 ++++++++++++
 tb/tb_render_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/render_scheduler_pkg.sv
// Shared rendering constants for the pixel-sweep scheduler: default geometry
// and the scheduler state encoding.
package render_scheduler_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    // Pixel index width sized to cover the X*Y product of the framebuffer.
    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_SCREEN_W = 160;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/render_scheduler_if.sv
// Client/framebuffer bundle for the render scheduler, plus a state debug tap.
interface render_scheduler_if
    import render_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W
);
    // Handshake: a pixel transfers on a posedge where pix_valid=1 and stall=0;
    // while stalled, pix_index/pix_x/pix_y hold. req stays high until done.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_limit;
    logic                      stall;
    logic [NUM_REQ-1:0]        grant;
    logic                      pix_valid;
    logic [ADDR_W-1:0]         pix_index;
    logic [X_W-1:0]            pix_x;
    logic [Y_W-1:0]            pix_y;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic [1:0]                dbg_state;

    modport master (
        output req, req_limit, stall,
        input  grant, pix_valid, pix_index, pix_x, pix_y, done, busy, dbg_state
    );

    modport slave (
        input  req, req_limit, stall,
        output grant, pix_valid, pix_index, pix_x, pix_y, done, busy, dbg_state
    );

endinterface

// File: rtl/render_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1.
module render_scheduler_rr_arbiter
    import render_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Round-robin owner of the shared pixel sweep: latches the winner's pixel count
// and walks index/x/y incrementally, honouring framebuffer stall.
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int SCREEN_W = DEF_SCREEN_W
) (
    input  logic               clk,
    input  logic               reset,
    render_scheduler_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_limit;
    logic [ADDR_W-1:0]  r_index;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_prev_done;
    logic               r_pix_valid;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [ADDR_W-1:0]  w_pick_limit;
    logic               w_consume;
    logic               w_last;

    // The client that just finished usually still holds req in the following
    // IDLE cycle; masking it stops an immediate re-grant of the same job.
    assign w_req        = bus.req & ~r_prev_done;
    assign w_pick_limit = bus.req_limit[int'(w_pick_idx)*ADDR_W +: ADDR_W];
    assign w_consume    = r_pix_valid && !bus.stall;
    assign w_last       = (r_index == (r_limit - ADDR_W'(1)));

    render_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= PTR_W'(NUM_REQ-1);
            r_limit     <= '0;
            r_index     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_prev_done <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_prev_done <= r_done;
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_pick_idx;
                        r_limit <= w_pick_limit;
                        r_index <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        if (w_pick_limit != '0) begin
                            r_pix_valid <= 1'b1;
                            r_state     <= SWEEP;
                        end else begin
                            r_done  <= w_pick;
                            r_state <= DONE;
                        end
                    end
                end
                SWEEP: begin
                    if (w_consume) begin
                        if (w_last) begin
                            r_pix_valid <= 1'b0;
                            r_done      <= r_grant;
                            r_state     <= DONE;
                        end else begin
                            r_index <= r_index + ADDR_W'(1);
                            // Row wrap replaces a divide by SCREEN_W.
                            if (r_x == X_W'(SCREEN_W-1)) begin
                                r_x <= '0;
                                r_y <= r_y + Y_W'(1);
                            end else begin
                                r_x <= r_x + X_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_index = r_index;
    assign bus.pix_x     = r_x;
    assign bus.pix_y     = r_y;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: pixel/done scoreboard queues fed by
// the job drivers and drained by a negedge monitor.
module tb_render_scheduler;
    import render_scheduler_pkg::*;

    localparam int NR = DEF_NUM_REQ;
    localparam int AW = DEF_ADDR_W;
    localparam int XW = DEF_X_W;
    localparam int YW = DEF_Y_W;
    localparam int SW = DEF_SCREEN_W;
    localparam int PW = NR + AW + XW + YW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    render_scheduler_if bus ();

    render_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] exp_q[$];
    logic [NR-1:0] done_q[$];
    int m_ptr = NR - 1;
    logic chk_idle_next = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int c);
        logic [NR-1:0] g;
        g    = '0;
        g[c] = 1'b1;
        return g;
    endfunction

    // Reference coordinates by division, independent of the incremental walk.
    function automatic logic [PW-1:0] pix_word(input int c, input int i);
        return {onehot(c), AW'(i), XW'(i % SW), YW'((i / SW) % (1 << YW))};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk_idle_next = 1'b0;
        end else begin
            if (chk_idle_next)
                check_eq("idle_after_done", {bus.busy, bus.grant}, '0);
            chk_idle_next = (bus.done != '0);
            if (bus.pix_valid && !bus.stall) begin
                if (exp_q.size() == 0) check_eq("pix_q_empty", bus.pix_valid, 0);
                else check_eq("pix", {bus.grant, bus.pix_index, bus.pix_x, bus.pix_y},
                              exp_q.pop_front());
            end
            if (bus.done != '0) begin
                if (done_q.size() == 0) check_eq("done_unexpected", bus.done, '0);
                else check_eq("done", bus.done, done_q.pop_front());
                check_eq("done_no_pix", bus.pix_valid, 0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = NR - 1;
    endtask

    task automatic run_job(input int c, input int limit, input int stall_at,
                           input int stall_len, input int drop_at);
        int k;
        int beats;
        bit done_seen;
        for (int i = 0; i < limit; i++) exp_q.push_back(pix_word(c, i));
        done_q.push_back(onehot(c));
        @(posedge clk); #1;
        bus.req_limit[c*AW +: AW] = AW'(limit);
        bus.req[c] = 1'b1;
        @(negedge clk);
        check_eq("idle_before_grant", bus.grant, '0);
        @(posedge clk); #1;
        k = 0; beats = 0; done_seen = 1'b0;
        while (!done_seen && k < limit + stall_len + 20) begin
            bus.stall = (k >= stall_at) && (k < stall_at + stall_len);
            @(negedge clk);
            if (k == 0) begin
                check_eq("grant_latency", bus.grant, onehot(c));
                check_eq("first_valid", bus.pix_valid, limit != 0);
            end
            if (bus.stall && bus.pix_valid) check_eq("stall_hold", bus.pix_index, stall_at);
            if (bus.pix_valid && !bus.stall) beats++;
            if (bus.done[c]) done_seen = 1'b1;
            @(posedge clk); #1;
            if (drop_at >= 0 && beats >= drop_at) bus.req[c] = 1'b0;
            k++;
        end
        bus.stall  = 1'b0;
        bus.req[c] = 1'b0;
        check_eq("job_done_seen", done_seen, 1);
        check_eq("job_beats", beats, limit);
        m_ptr = c;
    endtask

    task automatic run_rr(input logic [NR-1:0] mask, input int n_jobs);
        int order[$];
        int p;
        int k;
        int seen;
        int gidx;
        int cand;
        p = m_ptr;
        for (int j = 0; j < n_jobs; j++) begin
            for (int s = 1; s <= NR; s++) begin
                cand = (p + s) % NR;
                if (mask[cand]) begin
                    p = cand;
                    break;
                end
            end
            order.push_back(p);
            exp_q.push_back(pix_word(p, 0));
            done_q.push_back(onehot(p));
        end
        @(posedge clk); #1;
        for (int c = 0; c < NR; c++) bus.req_limit[c*AW +: AW] = AW'(1);
        bus.req = mask;
        seen = 0; k = 0; gidx = 0;
        while (seen < n_jobs && k < n_jobs * 8) begin
            @(negedge clk);
            if (bus.pix_valid && gidx < n_jobs) begin
                check_eq("rr_grant", bus.grant, onehot(order[gidx]));
                gidx++;
            end
            if (bus.done != '0) seen++;
            @(posedge clk); #1;
            if (seen == n_jobs) bus.req = '0;
            k++;
        end
        bus.req = '0;
        check_eq("rr_jobs", seen, n_jobs);
        m_ptr = p;
    endtask

    task automatic reset_mid_sweep(input int c, input int limit, input int at_idx);
        int k;
        bit hit;
        for (int i = 0; i <= at_idx; i++) exp_q.push_back(pix_word(c, i));
        @(posedge clk); #1;
        bus.req_limit[c*AW +: AW] = AW'(limit);
        bus.req[c] = 1'b1;
        k = 0; hit = 1'b0;
        while (!hit && k < limit + 10) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_index == AW'(at_idx)) hit = 1'b1;
            k++;
        end
        check_eq("reached_reset_idx", hit, 1);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_grant", bus.grant, '0);
        check_eq("rst_valid", bus.pix_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, '0);
        check_eq("rst_index", bus.pix_index, '0);
        bus.req = '0;
        reset = 1'b0;
        m_ptr = NR - 1;
        repeat (6) @(posedge clk);
        check_eq("rst_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        bus.req       = '0;
        bus.req_limit = '0;
        bus.stall     = 1'b0;
        do_reset();
        check_eq("reset_grant", bus.grant, '0);
        check_eq("reset_valid", bus.pix_valid, 0);
        check_eq("reset_index", bus.pix_index, '0);
        check_eq("reset_x", bus.pix_x, '0);
        check_eq("reset_y", bus.pix_y, '0);
        check_eq("reset_done", bus.done, '0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_state", bus.dbg_state, IDLE);

        run_job(0, 5, -1, 0, -1);
        run_job(1, SW + 2, -1, 0, -1);
        run_job(0, 3, 1, 4, -1);
        run_rr({NR{1'b1}}, NR + 1);
        run_job(2, 0, -1, 0, -1);
        run_job(3, 10, -1, 0, 3);
        run_job(2, 7, 6, 3, -1);
        reset_mid_sweep(0, 20, 7);
        run_rr(4'b0011, 2);
        run_job(1, 4, -1, 0, -1);
        run_rr(4'b1010, 3);

        repeat (4) @(posedge clk);
        check_eq("final_pix_q_empty", exp_q.size(), 0);
        check_eq("final_done_q_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
